// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter that shares one combinational binary-to-BCD converter between N_REQ requesters.
// Define BCD_OUT_REG_EN to add a register stage after the converter (state CONV2, +1 cycle latency).

module bin2bcd #(
    parameter int W    = 18,
    parameter int BCDW = W + (W - 4) / 3 + 1
) (
    input  logic [W-1:0]    bin,
    output logic [BCDW-1:0] bcd
);
    localparam int ND = (BCDW + 3) / 4;
    localparam int SW = ND * 4;

    // Double dabble on a whole-nibble scratch word; the bits above BCDW are
    // always zero for any W-bit operand, so dropping them is lossless.
    function automatic logic [BCDW-1:0] dabble(input logic [W-1:0] b);
        logic [SW-1:0] acc;
        acc = '0;
        for (int i = W - 1; i >= 0; i--) begin
            for (int d = 0; d < ND; d++) begin
                if (acc[d*4 +: 4] >= 4'd5) begin
                    acc[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
                end
            end
            acc = {acc[SW-2:0], b[i]};
        end
        return acc[BCDW-1:0];
    endfunction

    assign bcd = dabble(bin);
endmodule

module bcd_convert_arbiter #(
    parameter int  N_REQ = 4,
    parameter int  W     = 18,
    localparam int BCDW  = W + (W - 4) / 3 + 1,
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [N_REQ-1:0]     req_valid_in,
    input  logic [N_REQ*W-1:0]   req_bin_in,
    output logic [N_REQ-1:0]     req_ready_out,
    output logic                 resp_valid_out,
    output logic [IDW-1:0]       resp_id_out,
    output logic [BCDW-1:0]      resp_bcd_out,
    input  logic                 resp_ready_in
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        CONV2 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [IDW-1:0]    rr_reg;
    logic [IDW-1:0]    rr_next;
    logic [IDW-1:0]    grant_id_reg;
    logic [W-1:0]      operand_reg;
    logic [BCDW-1:0]   conv_bcd;
    logic [IDW-1:0]    grant_idx;
    logic              found;
    logic              accept;
`ifdef BCD_OUT_REG_EN
    logic [BCDW-1:0]   bcd_pipe_reg;
`endif

    bin2bcd #(.W(W), .BCDW(BCDW)) u_bin2bcd (
        .bin (operand_reg),
        .bcd (conv_bcd)
    );

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        int idx;
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_reg) + k) % N_REQ;
            if (!found && req_valid_in[idx]) begin
                found     = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        rr_next = '0;
        if (int'(grant_idx) != N_REQ - 1) begin
            rr_next = grant_idx + IDW'(1);
        end
    end

    assign accept = (state_reg == IDLE) && found;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready_out[gi] = accept && !rst_in && (grant_idx == IDW'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next = CONV;
                end
            end
            CONV: begin
`ifdef BCD_OUT_REG_EN
                state_next = CONV2;
`else
                state_next = RESP;
`endif
            end
            CONV2: state_next = RESP;
            RESP: begin
                if (resp_ready_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign resp_valid_out = (state_reg == RESP);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            rr_reg       <= '0;
            grant_id_reg <= '0;
            operand_reg  <= '0;
            resp_id_out  <= '0;
            resp_bcd_out <= '0;
`ifdef BCD_OUT_REG_EN
            bcd_pipe_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                operand_reg  <= req_bin_in[int'(grant_idx)*W +: W];
                grant_id_reg <= grant_idx;
                rr_reg       <= rr_next;
            end
            if (state_reg == CONV) begin
                resp_id_out <= grant_id_reg;
`ifdef BCD_OUT_REG_EN
                bcd_pipe_reg <= conv_bcd;
`else
                resp_bcd_out <= conv_bcd;
`endif
            end
`ifdef BCD_OUT_REG_EN
            if (state_reg == CONV2) begin
                resp_bcd_out <= bcd_pipe_reg;
            end
`endif
        end
    end
endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Scoreboard bench for bcd_convert_arbiter (N_REQ=4, W=18); works with or without BCD_OUT_REG_EN.

module tb_bcd_convert_arbiter;
    localparam int N_REQ = 4;
    localparam int W     = 18;
    localparam int BCDW  = 23;
`ifdef BCD_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b1;
    logic [N_REQ-1:0]   req_valid_in = '0;
    logic [N_REQ*W-1:0] req_bin_in = '0;
    logic [N_REQ-1:0]   req_ready_out;
    logic               resp_valid_out;
    logic [1:0]         resp_id_out;
    logic [BCDW-1:0]    resp_bcd_out;
    logic               resp_ready_in = 1'b1;

    bcd_convert_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_valid_in   (req_valid_in),
        .req_bin_in     (req_bin_in),
        .req_ready_out  (req_ready_out),
        .resp_valid_out (resp_valid_out),
        .resp_id_out    (resp_id_out),
        .resp_bcd_out   (resp_bcd_out),
        .resp_ready_in  (resp_ready_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0]      id;
        logic [BCDW-1:0] bcd;
        int              cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle_count = 0;
    logic in_resp = 1'b0;

    always @(posedge clk_in) cycle_count <= cycle_count + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per response, then checks it stays stable until taken.
    initial begin
        exp_t cur;
        cur = '{id: 2'd0, bcd: '0, cyc: 0};
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                in_resp = 1'b0;
            end else if (resp_valid_out) begin
                check("ready_low_in_resp", 64'(req_ready_out), 64'd0);
                if (!in_resp) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", 64'(resp_valid_out), 64'd0);
                    end else begin
                        cur = sb.pop_front();
                        check("resp_id", 64'(resp_id_out), 64'(cur.id));
                        check("resp_bcd", 64'(resp_bcd_out), 64'(cur.bcd));
                        check("resp_latency", 64'(cycle_count), 64'(cur.cyc));
                        $display("resp id=%0d bcd=%0h cycle=%0d", resp_id_out, resp_bcd_out, cycle_count);
                    end
                    in_resp = 1'b1;
                end else begin
                    check("stable_id", 64'(resp_id_out), 64'(cur.id));
                    check("stable_bcd", 64'(resp_bcd_out), 64'(cur.bcd));
                end
                if (resp_ready_in) in_resp = 1'b0;
            end
        end
    end

    // Waits for the next grant, checks which requester got it and optionally queues its result.
    task automatic expect_grant(input logic [3:0] onehot, input logic [1:0] id,
                                input logic [BCDW-1:0] bcd, input bit push);
        bit seen;
        exp_t e;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_in);
            if (req_ready_out != '0) seen = 1'b1;
        end
        if (!seen) begin
            check("grant_timeout", 64'd0, 64'd1);
        end else begin
            check("grant_onehot", 64'(req_ready_out), 64'(onehot));
            $display("grant ready=%b cycle=%0d", req_ready_out, cycle_count);
            if (push) begin
                e.id = id; e.bcd = bcd; e.cyc = cycle_count + LAT;
                sb.push_back(e);
            end
        end
        @(posedge clk_in); #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [W-1:0] b);
        req_valid_in[i] = v;
        req_bin_in[i*W +: W] = b;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk_in); #2;
            if (sb.size() == 0 && !resp_valid_out) done = 1'b1;
        end
        if (!done) check("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #1;
        check("rst_ready", 64'(req_ready_out), 64'd0);
        check("rst_valid", 64'(resp_valid_out), 64'd0);
        check("rst_id", 64'(resp_id_out), 64'd0);
        check("rst_bcd", 64'(resp_bcd_out), 64'd0);
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Burst: all four valid, pointer at 0
        set_req(0, 1, 18'd1); set_req(1, 1, 18'd22); set_req(2, 1, 18'd333); set_req(3, 1, 18'd4444);
        expect_grant(4'b0001, 2'd0, 23'h1, 1);    set_req(0, 0, 18'd0);
        expect_grant(4'b0010, 2'd1, 23'h22, 1);   set_req(1, 0, 18'd0);
        expect_grant(4'b0100, 2'd2, 23'h333, 1);  set_req(2, 0, 18'd0);
        expect_grant(4'b1000, 2'd3, 23'h4444, 1); set_req(3, 0, 18'd0);
        drain();

        // Fairness: req0 and req2 held high
        set_req(0, 1, 18'd100); set_req(2, 1, 18'd202);
        for (int k = 0; k < 3; k++) begin
            expect_grant(4'b0001, 2'd0, 23'h100, 1);
            expect_grant(4'b0100, 2'd2, 23'h202, 1);
        end
        set_req(0, 0, 18'd0); set_req(2, 0, 18'd0);
        drain();

        // Single request
        set_req(0, 1, 18'd12345);
        expect_grant(4'b0001, 2'd0, 23'h012345, 1);
        set_req(0, 0, 18'd0);
        drain();

        // Boundary operands on requester 1
        set_req(1, 1, 18'd0);      expect_grant(4'b0010, 2'd1, 23'h0, 1);      set_req(1, 0, 18'd0); drain();
        set_req(1, 1, 18'd262143); expect_grant(4'b0010, 2'd1, 23'h262143, 1); set_req(1, 0, 18'd0); drain();
        set_req(1, 1, 18'd9);      expect_grant(4'b0010, 2'd1, 23'h9, 1);      set_req(1, 0, 18'd0); drain();
        set_req(1, 1, 18'd10);     expect_grant(4'b0010, 2'd1, 23'h10, 1);     set_req(1, 0, 18'd0); drain();

        // Backpressure: consumer stalls well past the response; other requests must wait
        resp_ready_in = 1'b0;
        set_req(2, 1, 18'd777);
        expect_grant(4'b0100, 2'd2, 23'h777, 1);
        set_req(2, 0, 18'd0);
        set_req(3, 1, 18'd55);
        repeat (LAT + 5) @(posedge clk_in);
        #1;
        check("bp_valid_held", 64'(resp_valid_out), 64'd1);
        resp_ready_in = 1'b1;
        expect_grant(4'b1000, 2'd3, 23'h55, 1);
        set_req(3, 0, 18'd0);
        drain();

        // Reset while converting: no response may follow
        set_req(1, 1, 18'd555);
        expect_grant(4'b0010, 2'd1, 23'h555, 0);
        set_req(1, 0, 18'd0);
        rst_in = 1'b1;
        #1;
        check("midrst_valid", 64'(resp_valid_out), 64'd0);
        check("midrst_ready", 64'(req_ready_out), 64'd0);
        check("midrst_id", 64'(resp_id_out), 64'd0);
        check("midrst_bcd", 64'(resp_bcd_out), 64'd0);
        @(posedge clk_in); #1 rst_in = 1'b0;
        repeat (6) @(posedge clk_in);
        #1;
        set_req(3, 1, 18'd3000); set_req(0, 1, 18'd42);
        expect_grant(4'b0001, 2'd0, 23'h42, 1);   set_req(0, 0, 18'd0);
        expect_grant(4'b1000, 2'd3, 23'h3000, 1); set_req(3, 0, 18'd0);
        drain();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
